// File: rtl/bcd_select_arbiter.sv
// Round-robin arbiter that shares one active-low BCD select decoder among ten requesters.
// Drives the owner's index as a BCD code, or an idle code between grants, plus a one-hot copy.
module bcd_select_arbiter #(
  parameter int         MAX_HOLD    = 16,
  parameter int         DEAD_CYCLES = 1,
  parameter logic [3:0] IDLE_CODE   = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [9:0] req,
  output logic [3:0] sel_code,
  output logic [9:0] sel_n,
  output logic       gnt_valid,
  output logic       owner_to
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DEAD
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    code_q, code_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [3:0]    dead_q, dead_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [9:0]    seln_q, seln_d;
  logic          gnt_q, gnt_d;
  logic          to_q, to_d;

  logic [4:0]    cand_sum [10];
  logic [3:0]    cand     [10];
  logic [3:0]    winner;
  logic          found;
  logic [15:0]   req_ext;
  logic          owner_req;

  // Candidate k is the requester k places after the pointer, modulo 10.
  for (genvar gi = 0; gi < 10; gi++) begin : g_cand
    assign cand_sum[gi] = {1'b0, ptr_q} + 5'(gi);
    assign cand[gi]     = (cand_sum[gi] >= 5'd10) ? 4'(cand_sum[gi] - 5'd10) : cand_sum[gi][3:0];
  end

  assign req_ext   = {6'b0, req};
  assign owner_req = req_ext[code_q];

  always_comb begin
    winner = 4'd0;
    found  = 1'b0;
    for (int k = 9; k >= 0; k--) begin
      if (req_ext[cand[k]]) begin
        winner = cand[k];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    dead_d  = dead_q;
    to_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en && found) begin
          state_d = ST_GRANT;
          code_d  = winner;
          hold_d  = HW'(1);
        end
      end
      ST_GRANT: begin
        if (owner_req && (hold_q < HW'(MAX_HOLD))) begin
          hold_d = hold_q + HW'(1);
        end else begin
          // Released owner becomes lowest priority on the next search.
          state_d = ST_DEAD;
          to_d    = owner_req;
          ptr_d   = (code_q == 4'd9) ? 4'd0 : code_q + 4'd1;
          code_d  = IDLE_CODE;
          hold_d  = '0;
          dead_d  = 4'd1;
        end
      end
      ST_DEAD: begin
        if (dead_q >= 4'(DEAD_CYCLES)) begin
          state_d = ST_IDLE;
          dead_d  = 4'd0;
        end else begin
          dead_d = dead_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = IDLE_CODE;
      end
    endcase
    gnt_d = (state_d == ST_GRANT);
  end

  for (genvar gi = 0; gi < 10; gi++) begin : g_dec
    assign seln_d[gi] = (code_d != 4'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= IDLE_CODE;
      ptr_q   <= 4'd0;
      hold_q  <= '0;
      dead_q  <= 4'd0;
      seln_q  <= 10'h3FF;
      gnt_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
      seln_q  <= seln_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
    end
  end

  assign sel_code  = code_q;
  assign sel_n     = seln_q;
  assign gnt_valid = gnt_q;
  assign owner_to  = to_q;

endmodule
